dds_spi_mc: RTL and testbench

DDS_SPI_MC -- requirements
Module: dds_spi_mc

---
 rtl/dds_pkg.sv | 24 ++
 rtl/spi_word_tx.sv | 98 +++++++++
 rtl/dds_spi_mc.sv | 186 ++++++++++++++++++
 tb/tb_dds_spi_mc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS-to-SPI DAC frame sequencer.
package dds_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CS_SETUP = 3'd2,
    S_SHIFT    = 3'd3,
    S_CS_HOLD  = 3'd4,
    S_CS_GAP   = 3'd5,
    S_LDAC     = 3'd6
  } state_e;

  // Cycles cs_n stays high between words, and cycles ldac_n is held low.
  localparam int CS_GAP_CYC = 2;
  localparam int LDAC_CYC   = 2;
  localparam int CNT_W      = 2;

  // SPI word width: command, address, sample.
  function automatic int word_w(input int cmd_w, input int addr_w, input int data_w);
    return cmd_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_word_tx.sv
// Serializes one SPI word MSB first: load presets dout to the MSB, start
// launches W sclk periods (low CLK_DIV, high CLK_DIV), dout moves on falls.
module spi_word_tx
  import dds_pkg::*;
#(
  parameter int W       = 24,
  parameter int CLK_DIV = 1
) (
  input  logic         clk_dds,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         load,
  input  logic         start,
  input  logic [W-1:0] word,
  output logic         sclk,
  output logic         dout,
  output logic         done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(W);

  logic [W-1:0]     sh_q, sh_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d, dout_q, dout_d, run_q, run_d;
  logic             last_div;

  // Divider / shifter next state; done flags the final high half-period.
  always_comb begin
    sh_d     = sh_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    dout_d   = dout_q;
    run_d    = run_q;
    last_div = (div_q == DIV_W'(CLK_DIV - 1));
    done     = run_q && sclk_q && last_div && (bit_q == BIT_W'(W - 1));
    if (abort) begin
      run_d  = 1'b0;
      sclk_d = 1'b0;
      dout_d = 1'b0;
      div_d  = '0;
      bit_d  = '0;
    end else if (load) begin
      sh_d   = word;
      dout_d = word[W-1];
      sclk_d = 1'b0;
      run_d  = 1'b0;
      div_d  = '0;
      bit_d  = '0;
    end else if (start) begin
      run_d = 1'b1;
      div_d = '0;
    end else if (run_q) begin
      if (!last_div) begin
        div_d = div_q + DIV_W'(1);
      end else begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == BIT_W'(W - 1)) begin
            run_d = 1'b0;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sh_d   = sh_q << 1;
            dout_d = sh_q[W-2];
          end
        end
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
      dout_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
      dout_q <= dout_d;
      run_q  <= run_d;
    end
  end

  assign sclk = sclk_q;
  assign dout = dout_q;

endmodule

// File: rtl/dds_spi_mc.sv
// Multi-channel DAC frame sequencer: a frame timer launches a frame that
// writes each enabled channel over SPI, then pulses ldac_n to update all.
module dds_spi_mc
  import dds_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 16,
  parameter int CMD_W      = 4,
  parameter int ADDR_W     = 4,
  parameter int CLK_DIV    = 1,
  parameter int OFFSET_BIN = 1
) (
  input  logic                   clk_dds,
  input  logic                   rst_n,
  input  logic                   out_en,
  input  logic [15:0]            frame_period,
  input  logic [CMD_W-1:0]       cmd,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_mask,
  output logic                   cs_n,
  output logic                   sclk,
  output logic                   dout,
  output logic                   ldac_n,
  output logic                   da_clr,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int W    = word_w(CMD_W, ADDR_W, DATA_W);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e                  state_q, state_d;
  logic [15:0]             timer_q, timer_d, per;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_CH*DATA_W-1:0]  data_q, data_d;
  logic [N_CH-1:0]         pend_q, pend_d;
  logic [CMD_W-1:0]        cmd_q, cmd_d;
  logic                    cs_n_q, cs_n_d, ldac_n_q, ldac_n_d, busy_q, busy_d;
  logic                    fd_q, fd_d, ovr_q, ovr_d, da_clr_q;
  logic                    tick, tx_load, tx_start, tx_done;
  logic [CH_W-1:0]         nxt_ch;
  logic                    nxt_vld;
  logic [DATA_W-1:0]       samp;
  logic [W-1:0]            tx_word;

  // Lowest still-pending channel, and the SPI word that goes with it.
  always_comb begin
    nxt_ch  = '0;
    nxt_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        nxt_ch  = CH_W'(i);
        nxt_vld = 1'b1;
      end
    end
    samp = data_q[nxt_ch*DATA_W +: DATA_W];
    if (OFFSET_BIN != 0) samp[DATA_W-1] = ~samp[DATA_W-1];
    tx_word = {cmd_q, ADDR_W'(nxt_ch), samp};
  end

  // Frame timer, sequencing FSM and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    pend_d   = pend_q;
    cmd_d    = cmd_q;
    fd_d     = 1'b0;
    ovr_d    = ovr_q;
    tx_load  = 1'b0;
    tx_start = 1'b0;
    per      = (frame_period == 16'd0) ? 16'd1 : frame_period;
    tick     = out_en && (timer_q == per - 16'd1);
    timer_d  = (!out_en || tick) ? 16'd0 : timer_q + 16'd1;
    if (tick && state_q != S_IDLE) ovr_d = 1'b1;
    case (state_q)
      S_IDLE: if (tick) begin
        state_d = S_LOAD;
        data_d  = ch_data;
        pend_d  = ch_mask;
        cmd_d   = cmd;
      end
      S_LOAD: if (!nxt_vld) begin
        state_d = S_IDLE;
        fd_d    = 1'b1;
      end else begin
        state_d        = S_CS_SETUP;
        tx_load        = 1'b1;
        pend_d[nxt_ch] = 1'b0;
      end
      S_CS_SETUP: begin
        state_d  = S_SHIFT;
        tx_start = 1'b1;
      end
      S_SHIFT: if (tx_done) state_d = S_CS_HOLD;
      S_CS_HOLD: begin
        state_d = S_CS_GAP;
        cnt_d   = '0;
      end
      S_CS_GAP: if (cnt_q == CNT_W'(CS_GAP_CYC - 1)) begin
        cnt_d = '0;
        if (nxt_vld) begin
          state_d        = S_CS_SETUP;
          tx_load        = 1'b1;
          pend_d[nxt_ch] = 1'b0;
        end else begin
          state_d = S_LDAC;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_LDAC: if (cnt_q == CNT_W'(LDAC_CYC - 1)) begin
        cnt_d   = '0;
        state_d = S_IDLE;
        fd_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Disable wins over everything: abandon the frame and clear overrun.
    if (!out_en) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      fd_d     = 1'b0;
      ovr_d    = 1'b0;
      tx_load  = 1'b0;
      tx_start = 1'b0;
    end
    cs_n_d   = !(state_d inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
    ldac_n_d = (state_d != S_LDAC);
    busy_d   = (state_d != S_IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      pend_q   <= '0;
      cmd_q    <= '0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
      ovr_q    <= 1'b0;
      da_clr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      cmd_q    <= cmd_d;
      cs_n_q   <= cs_n_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
      ovr_q    <= ovr_d;
      da_clr_q <= out_en;
    end
  end

  spi_word_tx #(.W(W), .CLK_DIV(CLK_DIV)) u_tx (
    .clk_dds (clk_dds),
    .rst_n   (rst_n),
    .abort   (!out_en),
    .load    (tx_load),
    .start   (tx_start),
    .word    (tx_word),
    .sclk    (sclk),
    .dout    (dout),
    .done    (tx_done)
  );

  assign cs_n       = cs_n_q;
  assign ldac_n     = ldac_n_q;
  assign da_clr     = da_clr_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_dds_spi_mc.sv
// Scoreboard bench for dds_spi_mc: stimulus pushes expected SPI words, a
// negedge monitor decodes the bus and pops/compares completed words.
module tb_dds_spi_mc;

  localparam int W = 24;

  logic        clk_dds = 1'b0;
  logic        rst_n   = 1'b0;
  logic        out_en  = 1'b0;
  logic [15:0] frame_period = 16'd400;
  logic [3:0]  cmd     = 4'h3;
  logic [63:0] ch_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  logic [3:0]  ch_mask = 4'hf;
  logic        cs_n, sclk, dout, ldac_n, da_clr, busy, frame_done, overrun;

  int n_chk = 0, n_fail = 0;
  logic [W-1:0] sb[$];
  int fd_cnt = 0, ldac_cnt = 0, sclk_rise = 0, cs_fall = 0;
  bit allow_partial = 1'b0;

  always #5 clk_dds = ~clk_dds;

  dds_spi_mc dut (
    .clk_dds(clk_dds), .rst_n(rst_n), .out_en(out_en), .frame_period(frame_period),
    .cmd(cmd), .ch_data(ch_data), .ch_mask(ch_mask), .cs_n(cs_n), .sclk(sclk),
    .dout(dout), .ldac_n(ldac_n), .da_clr(da_clr), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Bus monitor: decode words, measure cs gaps and ldac pulses.
  logic p_cs = 1'b1, p_sclk = 1'b0, p_ldac = 1'b1;
  logic [W-1:0] sh = '0;
  int nb = 0, lcnt = 0, gap = 0, wif = 0;
  always @(negedge clk_dds) begin
    if (rst_n) begin
      if (!p_sclk && sclk) begin
        sclk_rise++;
        if (!cs_n) begin sh = {sh[W-2:0], dout}; nb++; end
      end
      if (p_cs && !cs_n) begin
        cs_fall++;
        if (wif > 0) chk("cs_gap", gap, 2);
        nb = 0;
        sh = '0;
      end
      if (!p_cs && cs_n) begin
        if (nb == W) begin
          chk("sb_has_entry", sb.size() != 0, 1);
          if (sb.size() != 0) chk("spi_word", sh, sb.pop_front());
        end else if (!allow_partial) begin
          chk("word_bits", nb, W);
        end
        wif++;
      end
      gap = cs_n ? gap + 1 : 0;
      if (!busy) wif = 0;
      if (!ldac_n) lcnt++;
      else if (!p_ldac) begin
        chk("ldac_len", lcnt, 2);
        ldac_cnt++;
        lcnt = 0;
      end
      if (frame_done) fd_cnt++;
    end else begin
      nb = 0; lcnt = 0; gap = 0; wif = 0;
    end
    p_cs = cs_n; p_sclk = sclk; p_ldac = ldac_n;
  end

  task automatic step();
    @(negedge clk_dds);
    #1;
  endtask

  task automatic wait_fd(input int target, input int lim);
    int t = 0;
    while (fd_cnt < target && t < lim) begin step(); t++; end
    chk("frame_done_wait", fd_cnt >= target, 1);
  endtask

  task automatic wait_cs(input int target, input int lim);
    int t = 0;
    while (cs_fall < target && t < lim) begin step(); t++; end
    chk("cs_fall_wait", cs_fall >= target, 1);
  endtask

  task automatic chk_rst_vals();
    chk("rst_cs_n", cs_n, 1);     chk("rst_sclk", sclk, 0);
    chk("rst_dout", dout, 0);     chk("rst_ldac_n", ldac_n, 1);
    chk("rst_da_clr", da_clr, 0); chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0); chk("rst_overrun", overrun, 0);
  endtask

  int t, b_fd, b_ld, b_cs, b_sr;

  initial begin
    #23;
    chk_rst_vals();
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Full frame, all four channels.
    sb.push_back(24'h308001); sb.push_back(24'h318002);
    sb.push_back(24'h328003); sb.push_back(24'h338004);
    b_fd = fd_cnt; b_ld = ldac_cnt;
    out_en = 1'b1;
    t = 0;
    while (!busy && t < 1000) begin step(); t++; end
    chk("first_tick_latency", t, 400);
    chk("da_clr_follows", da_clr, 1);
    wait_fd(b_fd + 1, 1000);
    chk("overrun_clean", overrun, 0);
    out_en = 1'b0;
    repeat (3) step();
    chk("frames_full", fd_cnt - b_fd, 1);
    chk("ldac_pulses_full", ldac_cnt - b_ld, 1);
    chk("sb_drained_full", sb.size(), 0);
    chk("da_clr_low", da_clr, 0);

    // Sparse mask: channels 0 and 2 only.
    ch_mask = 4'b0101;
    sb.push_back(24'h308001); sb.push_back(24'h328003);
    b_fd = fd_cnt; b_ld = ldac_cnt; b_cs = cs_fall;
    out_en = 1'b1;
    wait_fd(b_fd + 1, 1000);
    out_en = 1'b0;
    repeat (3) step();
    chk("words_sparse", cs_fall - b_cs, 2);
    chk("ldac_pulses_sparse", ldac_cnt - b_ld, 1);
    chk("sb_drained_sparse", sb.size(), 0);

    // Empty mask: frame_done each tick, bus silent.
    ch_mask = 4'b0000; frame_period = 16'd20;
    b_fd = fd_cnt; b_ld = ldac_cnt; b_cs = cs_fall; b_sr = sclk_rise;
    out_en = 1'b1;
    repeat (110) step();
    out_en = 1'b0;
    repeat (3) step();
    chk("frames_empty", fd_cnt - b_fd, 5);
    chk("cs_quiet_empty", cs_fall - b_cs, 0);
    chk("sclk_quiet_empty", sclk_rise - b_sr, 0);
    chk("ldac_quiet_empty", ldac_cnt - b_ld, 0);

    // Overrun: period shorter than a four-channel frame.
    ch_mask = 4'hf; frame_period = 16'd50;
    repeat (2) begin
      sb.push_back(24'h308001); sb.push_back(24'h318002);
      sb.push_back(24'h328003); sb.push_back(24'h338004);
    end
    b_fd = fd_cnt; b_ld = ldac_cnt;
    out_en = 1'b1;
    wait_fd(b_fd + 1, 600);
    chk("overrun_set", overrun, 1);
    wait_fd(b_fd + 2, 600);
    chk("overrun_sticky", overrun, 1);
    out_en = 1'b0;
    repeat (2) step();
    chk("overrun_cleared", overrun, 0);
    chk("ldac_pulses_ovr", ldac_cnt - b_ld, 2);
    chk("sb_drained_ovr", sb.size(), 0);

    // Abort in the middle of channel 1's shift.
    frame_period = 16'd400;
    sb.push_back(24'h308001);
    b_cs = cs_fall;
    out_en = 1'b1;
    wait_cs(b_cs + 2, 1000);
    repeat (10) step();
    allow_partial = 1'b1;
    b_fd = fd_cnt; b_ld = ldac_cnt;
    out_en = 1'b0;
    step();
    chk("abort_cs_n", cs_n, 1);   chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);   chk("abort_dout", dout, 0);
    chk("abort_ldac_n", ldac_n, 1);
    repeat (20) step();
    chk("abort_no_ldac", ldac_cnt - b_ld, 0);
    chk("abort_no_done", fd_cnt - b_fd, 0);
    chk("sb_drained_abort", sb.size(), 0);

    // Asynchronous reset in the middle of a word.
    b_cs = cs_fall;
    out_en = 1'b1;
    wait_cs(b_cs + 1, 1000);
    repeat (5) step();
    @(posedge clk_dds);
    #2 rst_n = 1'b0;
    #1 chk_rst_vals();
    step();
    out_en = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    chk("sb_drained_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
